// File: rtl/rtc_lectura_secuenciador_pkg.sv
// Shared constants for the RTC read sequencer: RTC address table, local
// register indices and the sequencer state encoding.
package rtc_lectura_secuenciador_pkg;

  localparam int N_REGS = 10;

  // Local indices as seen by the downstream distribution logic.
  localparam logic [3:0] IDX_SEG_HORA   = 4'd0;
  localparam logic [3:0] IDX_MIN_HORA   = 4'd1;
  localparam logic [3:0] IDX_HORA_HORA  = 4'd2;
  localparam logic [3:0] IDX_DIA_FECHA  = 4'd3;
  localparam logic [3:0] IDX_MES_FECHA  = 4'd4;
  localparam logic [3:0] IDX_ANIO_FECHA = 4'd5;
  localparam logic [3:0] IDX_DIA_SEMANA = 4'd6;
  localparam logic [3:0] IDX_SEG_TIMER  = 4'd7;
  localparam logic [3:0] IDX_MIN_TIMER  = 4'd8;
  localparam logic [3:0] IDX_HORA_TIMER = 4'd9;
  localparam logic [3:0] IDX_NINGUNO    = 4'hF;

  // RTC bus address for each local index: time, date, weekday, timer.
  localparam logic [7:0] RTC_ADDR [N_REGS] = '{
    8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27,
    8'h41, 8'h42, 8'h43
  };

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR_SET  = 4'd1,
    ST_ADDR_WR   = 4'd2,
    ST_ADDR_HOLD = 4'd3,
    ST_DATA_SET  = 4'd4,
    ST_DATA_RD   = 4'd5,
    ST_DATA_END  = 4'd6,
    ST_PUBLICA   = 4'd7,
    ST_FIN       = 4'd8
  } estado_t;

  // Table lookup; indices outside the table map to address 0.
  function automatic logic [7:0] rtc_addr(input logic [3:0] idx);
    logic [7:0] r;
    r = 8'h00;
    for (int k = 0; k < N_REGS; k++) begin
      if (idx == 4'(k)) r = RTC_ADDR[k];
    end
    return r;
  endfunction

endpackage

// File: rtl/rtc_lectura_secuenciador_fase.sv
// Bus phase timer: counts T_FASE cycles while enabled and pulses fin_fase
// on the last cycle of each phase. Held at zero while disabled, and wraps
// to zero on every phase change.
module rtc_fase_contador #(
  parameter int T_FASE = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic i_habilita,
  output logic o_fin_fase
);

  logic [7:0] r_cnt;
  logic       w_fin;

  assign w_fin      = i_habilita && (r_cnt == 8'(T_FASE - 1));
  assign o_fin_fase = w_fin;

  // Phase counter: restart at every phase boundary or when not in a bus phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= 8'd0;
    end else if (!i_habilita || w_fin) begin
      r_cnt <= 8'd0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/rtc_lectura_secuenciador.sv
// RTC read sequencer. A start pulse sweeps the ten RTC registers over the
// multiplexed AD bus and publishes each byte with its local index.
//
// Output handshake: out_dato_valid is a one-cycle strobe with no
// back-pressure. out_addr_mem_local and out_dato_rtc qualify only while it
// is high; otherwise the index is parked at 4'hF and the byte holds the
// last published value. out_done strobes once, one cycle after the last
// publish. in_start is accepted only in IDLE; anything else is dropped.
//
// Bus outputs are decoded from the state register alone, so the async
// reset releases every strobe in the same cycle it is applied.
module rtc_lectura_secuenciador
  import rtc_lectura_secuenciador_pkg::*;
#(
  parameter int T_FASE = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_start,
  input  logic [7:0] in_bus_dato,
  output logic [7:0] out_bus_dato,
  output logic       out_bus_oe,
  output logic       out_cs_n,
  output logic       out_ad_n,
  output logic       out_wr_n,
  output logic       out_rd_n,
  output logic [3:0] out_addr_mem_local,
  output logic [7:0] out_dato_rtc,
  output logic       out_dato_valid,
  output logic       out_busy,
  output logic       out_done,
  output logic [3:0] out_dbg_estado
);

  estado_t    r_estado;
  estado_t    w_sig_estado;
  logic [3:0] r_idx;
  logic [7:0] r_dato_hold;
  logic [7:0] r_dato_rtc;
  logic       w_en_fase;
  logic       w_fin_fase;

  assign w_en_fase = (r_estado == ST_ADDR_SET)  || (r_estado == ST_ADDR_WR) ||
                     (r_estado == ST_ADDR_HOLD) || (r_estado == ST_DATA_SET) ||
                     (r_estado == ST_DATA_RD)   || (r_estado == ST_DATA_END);

  rtc_fase_contador #(.T_FASE(T_FASE)) u_fase (
    .clk        (clk),
    .reset      (reset),
    .i_habilita (w_en_fase),
    .o_fin_fase (w_fin_fase)
  );

  assign out_dato_rtc   = r_dato_rtc;
  assign out_dbg_estado = r_estado;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_estado <= ST_IDLE;
    else        r_estado <= w_sig_estado;
  end

  // Register index, bus sample on the last read cycle, and the published byte
  // (moved from the holding register so it changes only at publish time).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx       <= IDX_SEG_HORA;
      r_dato_hold <= 8'h00;
      r_dato_rtc  <= 8'h00;
    end else begin
      if (r_estado == ST_IDLE && in_start) r_idx <= IDX_SEG_HORA;
      if (r_estado == ST_PUBLICA && r_idx != IDX_HORA_TIMER) r_idx <= r_idx + 4'd1;
      if (r_estado == ST_DATA_RD && w_fin_fase) r_dato_hold <= in_bus_dato;
      if (r_estado == ST_DATA_END && w_fin_fase) r_dato_rtc <= r_dato_hold;
    end
  end

  // Next state and bus/status decode. cs stays low across all six bus phases
  // and is released when DATA_END completes.
  always_comb begin
    w_sig_estado       = r_estado;
    out_cs_n           = 1'b1;
    out_ad_n           = 1'b1;
    out_wr_n           = 1'b1;
    out_rd_n           = 1'b1;
    out_bus_oe         = 1'b0;
    out_bus_dato       = 8'h00;
    out_addr_mem_local = IDX_NINGUNO;
    out_dato_valid     = 1'b0;
    out_busy           = 1'b1;
    out_done           = 1'b0;
    case (r_estado)
      ST_IDLE: begin
        out_busy = 1'b0;
        if (in_start) w_sig_estado = ST_ADDR_SET;
      end
      ST_ADDR_SET: begin
        out_cs_n     = 1'b0;
        out_ad_n     = 1'b0;
        out_bus_oe   = 1'b1;
        out_bus_dato = rtc_addr(r_idx);
        if (w_fin_fase) w_sig_estado = ST_ADDR_WR;
      end
      ST_ADDR_WR: begin
        out_cs_n     = 1'b0;
        out_ad_n     = 1'b0;
        out_wr_n     = 1'b0;
        out_bus_oe   = 1'b1;
        out_bus_dato = rtc_addr(r_idx);
        if (w_fin_fase) w_sig_estado = ST_ADDR_HOLD;
      end
      ST_ADDR_HOLD: begin
        out_cs_n     = 1'b0;
        out_ad_n     = 1'b0;
        out_bus_oe   = 1'b1;
        out_bus_dato = rtc_addr(r_idx);
        if (w_fin_fase) w_sig_estado = ST_DATA_SET;
      end
      ST_DATA_SET: begin
        out_cs_n = 1'b0;
        if (w_fin_fase) w_sig_estado = ST_DATA_RD;
      end
      ST_DATA_RD: begin
        out_cs_n = 1'b0;
        out_rd_n = 1'b0;
        if (w_fin_fase) w_sig_estado = ST_DATA_END;
      end
      ST_DATA_END: begin
        out_cs_n = 1'b0;
        if (w_fin_fase) w_sig_estado = ST_PUBLICA;
      end
      ST_PUBLICA: begin
        out_addr_mem_local = r_idx;
        out_dato_valid     = 1'b1;
        w_sig_estado       = (r_idx == IDX_HORA_TIMER) ? ST_FIN : ST_ADDR_SET;
      end
      ST_FIN: begin
        out_busy     = 1'b0;
        out_done     = 1'b1;
        w_sig_estado = ST_IDLE;
      end
      default: begin
        out_busy     = 1'b0;
        w_sig_estado = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rtc_lectura_secuenciador.sv
// Bench for the RTC read sequencer: bus model answering addr ^ key, expected
// publishes queued at start time, checked by a negedge monitor.
module tb_rtc_lectura_secuenciador;

  localparam int T   = 2;
  localparam int LAT = 6 * T + 1;
  localparam int NR  = 10;
  localparam int W   = 44;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_start = 1'b0;
  logic [7:0] in_bus_dato = 8'h00;
  logic [7:0] out_bus_dato;
  logic       out_bus_oe, out_cs_n, out_ad_n, out_wr_n, out_rd_n;
  logic [3:0] out_addr_mem_local;
  logic [7:0] out_dato_rtc;
  logic       out_dato_valid, out_busy, out_done;
  logic [3:0] out_dbg_estado;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [W-1:0] exp_q[$];
  int           done_q[$];
  logic [W-1:0] e;
  logic [7:0]   bus_key = 8'h5A;
  logic [7:0]   bus_lat = 8'h00;
  logic [7:0]   last_dato = 8'h00;
  logic [7:0]   ref_addr [NR] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27,
                                  8'h41, 8'h42, 8'h43};
  int cs_run = 0, wr_run = 0, rd_run = 0;

  rtc_lectura_secuenciador #(.T_FASE(T)) dut (
    .clk                (clk),
    .reset              (reset),
    .in_start           (in_start),
    .in_bus_dato        (in_bus_dato),
    .out_bus_dato       (out_bus_dato),
    .out_bus_oe         (out_bus_oe),
    .out_cs_n           (out_cs_n),
    .out_ad_n           (out_ad_n),
    .out_wr_n           (out_wr_n),
    .out_rd_n           (out_rd_n),
    .out_addr_mem_local (out_addr_mem_local),
    .out_dato_rtc       (out_dato_rtc),
    .out_dato_valid     (out_dato_valid),
    .out_busy           (out_busy),
    .out_done           (out_done),
    .out_dbg_estado     (out_dbg_estado)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h want 0x%0h", name, cyc, act, exp);
    end
  endfunction

  // RTC bus model: latch address under wr, answer addr ^ key under rd, noise otherwise.
  always @(posedge clk) if (!out_wr_n) bus_lat <= out_bus_dato;
  always @(negedge clk) in_bus_dato = !out_rd_n ? (bus_lat ^ bus_key) : 8'($urandom);

  // Monitor: strobe widths, strobe exclusion rules, publishes and done.
  always @(negedge clk) begin
    if (!reset) begin
      cs_run = 0; wr_run = 0; rd_run = 0; last_dato = 8'h00;
    end else begin
      if (!out_cs_n) cs_run++;
      else if (cs_run != 0) begin chk("cs_low_len", cs_run, 6 * T); cs_run = 0; end
      if (!out_wr_n) wr_run++;
      else if (wr_run != 0) begin chk("wr_low_len", wr_run, T); wr_run = 0; end
      if (!out_rd_n) rd_run++;
      else if (rd_run != 0) begin chk("rd_low_len", rd_run, T); rd_run = 0; end
      if (!out_wr_n) begin
        chk("wr_needs_ad0", int'(out_ad_n), 0);
        chk("wr_needs_oe", int'(out_bus_oe), 1);
      end
      if (out_bus_oe) chk("oe_implies_rd_high", int'(out_rd_n), 1);
      if (!out_rd_n) chk("rd_needs_ad1", int'(out_ad_n), 1);
      if (out_dato_valid) begin
        chk("valid_expected", int'(exp_q.size() > 0), 1);
        chk("busy_at_publish", int'(out_busy), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("publish_cycle", cyc, int'(e[43:12]));
          chk("publish_idx", int'(out_addr_mem_local), int'(e[11:8]));
          chk("publish_data", int'(out_dato_rtc), int'(e[7:0]));
          last_dato = e[7:0];
        end
      end else begin
        chk("idx_parked", int'(out_addr_mem_local), 15);
        chk("dato_held", int'(out_dato_rtc), int'(last_dato));
      end
      if (out_done) begin
        chk("done_expected", int'(done_q.size() > 0), 1);
        if (done_q.size() > 0) chk("done_cycle", cyc, done_q.pop_front());
        chk("busy_at_done", int'(out_busy), 0);
        chk("pubs_before_done", exp_q.size(), 0);
      end
    end
  end

  // Driver: pulse start at cycle tgt; when it should be accepted, queue the sweep.
  task automatic start_at(input int tgt, input bit acc, input logic [7:0] key, output int s);
    int guard;
    guard = 0;
    while (cyc < tgt && guard < 5000) begin @(posedge clk); #1; guard++; end
    s = cyc;
    in_start = 1'b1;
    if (acc) begin
      bus_key = key;
      for (int i = 0; i < NR; i++)
        exp_q.push_back({32'(s + LAT * (i + 1)), 4'(i), ref_addr[i] ^ key});
      done_q.push_back(s + NR * LAT + 1);
    end
    @(posedge clk); #1;
    in_start = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 1000; k++) begin
      if (exp_q.size() == 0 && done_q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("sweep_finished", exp_q.size() + done_q.size(), 0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_cs_n"}, int'(out_cs_n), 1);
    chk({tag, "_ad_n"}, int'(out_ad_n), 1);
    chk({tag, "_wr_n"}, int'(out_wr_n), 1);
    chk({tag, "_rd_n"}, int'(out_rd_n), 1);
    chk({tag, "_oe"}, int'(out_bus_oe), 0);
    chk({tag, "_addr"}, int'(out_addr_mem_local), 15);
    chk({tag, "_valid"}, int'(out_dato_valid), 0);
    chk({tag, "_busy"}, int'(out_busy), 0);
    chk({tag, "_done"}, int'(out_done), 0);
  endtask

  initial begin
    int s, s2, d, gap;
    logic [7:0] key;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    chk("reset_bus_dato", int'(out_bus_dato), 0);
    chk("reset_dato_rtc", int'(out_dato_rtc), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Full sweep, ignored starts mid-sweep and in FIN, then back-to-back sweep.
    start_at(cyc + 2, 1'b1, 8'h5A, s);
    start_at(s + 4 * LAT + 8, 1'b0, 8'h00, d);
    start_at(s + NR * LAT + 1, 1'b0, 8'h00, d);
    start_at(s + NR * LAT + 2, 1'b1, 8'h5A, s2);
    wait_drain();

    // Reset during DATA_RD of index 3.
    start_at(cyc + 3, 1'b1, 8'hA5, s);
    while (cyc < s + 3 * LAT + 9) begin @(posedge clk); #1; end
    chk("rd_low_before_reset", int'(out_rd_n), 0);
    #2;
    reset = 1'b0;
    exp_q.delete();
    done_q.delete();
    #1;
    chk_idle_outputs("midreset");
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    // Restart after reset begins again at index 0.
    start_at(cyc + 2, 1'b1, 8'h3C, s);
    wait_drain();

    // Randomized sweeps with a stray start somewhere inside each.
    repeat (4) begin
      gap = $urandom_range(1, 15);
      key = 8'($urandom);
      start_at(cyc + gap, 1'b1, key, s);
      start_at(s + $urandom_range(1, NR * LAT + 1), 1'b0, 8'h00, d);
      wait_drain();
    end

    repeat (5) @(posedge clk);
    #1;
    chk("final_exp_q_empty", exp_q.size(), 0);
    chk("final_done_q_empty", done_q.size(), 0);
    chk_idle_outputs("final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
